bytepipe_arbiter: RTL

Two-way BytePipe arbiter that shares one BytePipe register slave (the correlator register block) between two hosts, e.g. USB and UART. It sits between the host-side BytePipe links and the register block's BytePipe input/output pair. It grants the whole bidirectional link to one master at a time. The grant is held until the link has been quiet for a programmable number of cycles, so command, data, readback and burst bytes are never interleaved between hosts.

---
 rtl/bytepipe_pkg.sv | 17 +
 rtl/bytepipe_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bytepipe_pkg.sv
// Shared BytePipe definitions: data width, arbiter state encoding, counter sizing.
package bytepipe_pkg;

  localparam int unsigned BP_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Width needed to count 0..idle_cycles (never less than one bit).
  function automatic int unsigned quiet_cnt_w(input int unsigned idle_cycles);
    return (idle_cycles < 1) ? 1 : $clog2(idle_cycles + 1);
  endfunction

endpackage

// File: rtl/bytepipe_arbiter.sv
// Two-way BytePipe arbiter: grants the whole bidirectional link to one master
// and releases it after IDLE_CYCLES consecutive quiet cycles.
// Optional macro BYTEPIPE_ARBITER_FIXEDPRIO_EN: m0 always wins contention
// (no round-robin history register).
module bytepipe_arbiter
  import bytepipe_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [BP_DATA_W-1:0] i_m0_data,
  input  logic                 i_m0_valid,
  output logic                 o_m0_ready,
  output logic [BP_DATA_W-1:0] o_m0_data,
  output logic                 o_m0_valid,
  input  logic                 i_m0_ready,
  input  logic [BP_DATA_W-1:0] i_m1_data,
  input  logic                 i_m1_valid,
  output logic                 o_m1_ready,
  output logic [BP_DATA_W-1:0] o_m1_data,
  output logic                 o_m1_valid,
  input  logic                 i_m1_ready,
  output logic [BP_DATA_W-1:0] o_s_data,
  output logic                 o_s_valid,
  input  logic                 i_s_ready,
  input  logic [BP_DATA_W-1:0] i_s_data,
  input  logic                 i_s_valid,
  output logic                 o_s_ready,
  output logic                 o_owner,
  output logic                 o_locked
);

  localparam int unsigned     CNT_W    = quiet_cnt_w(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);

  arb_state_t       r_state;
  arb_state_t       w_next_state;
  logic [CNT_W-1:0] r_quiet_cnt;
  logic             w_own_valid;
  logic             w_own_ready;
  logic             w_quiet;
  logic             w_pick_m1;

  // Owner-side handshake signals, zero when nobody owns the link
  assign w_own_valid = (r_state == OWN0) ? i_m0_valid :
                       (r_state == OWN1) ? i_m1_valid : 1'b0;
  assign w_own_ready = (r_state == OWN0) ? i_m0_ready :
                       (r_state == OWN1) ? i_m1_ready : 1'b0;

  // Quiet: nothing offered or transferred in either direction on the owned link
  assign w_quiet = !(w_own_valid && i_s_ready) && !(i_s_valid && w_own_ready) &&
                   !w_own_valid && !i_s_valid;

`ifdef BYTEPIPE_ARBITER_FIXEDPRIO_EN
  assign w_pick_m1 = 1'b0;
`else
  logic r_last_grant;

  assign w_pick_m1 = !r_last_grant;

  // Remember the most recent grant so contention alternates
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last_grant <= 1'b1;
    end else if ((r_state == IDLE) && (w_next_state != IDLE)) begin
      r_last_grant <= (w_next_state == OWN1);
    end
  end
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Consecutive quiet cycles while owned; cleared in IDLE and on any activity
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_quiet_cnt <= '0;
    end else if ((r_state == IDLE) || !w_quiet) begin
      r_quiet_cnt <= '0;
    end else begin
      r_quiet_cnt <= r_quiet_cnt + CNT_W'(1);
    end
  end

  // Next state: grant from IDLE, release after the quiet window expires
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_m0_valid && i_m1_valid) begin
          w_next_state = w_pick_m1 ? OWN1 : OWN0;
        end else if (i_m0_valid) begin
          w_next_state = OWN0;
        end else if (i_m1_valid) begin
          w_next_state = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (w_quiet && (r_quiet_cnt == CNT_LAST)) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs: zero-latency forwarding between the owner and the slave only
  always_comb begin
    o_m0_ready = 1'b0;
    o_m0_data  = '0;
    o_m0_valid = 1'b0;
    o_m1_ready = 1'b0;
    o_m1_data  = '0;
    o_m1_valid = 1'b0;
    o_s_data   = '0;
    o_s_valid  = 1'b0;
    o_s_ready  = 1'b0;
    o_locked   = (r_state != IDLE);
    o_owner    = (r_state == OWN1);
    case (r_state)
      OWN0: begin
        o_s_data   = i_m0_data;
        o_s_valid  = i_m0_valid;
        o_m0_ready = i_s_ready;
        o_m0_data  = i_s_data;
        o_m0_valid = i_s_valid;
        o_s_ready  = i_m0_ready;
      end
      OWN1: begin
        o_s_data   = i_m1_data;
        o_s_valid  = i_m1_valid;
        o_m1_ready = i_s_ready;
        o_m1_data  = i_s_data;
        o_m1_valid = i_s_valid;
        o_s_ready  = i_m1_ready;
      end
      default: ;
    endcase
  end

endmodule
